fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 12-bit-address, 16-bit-word instruction memory.
- Owns the program counter and drives the memory address; the memory returns the word combinationally in the same cycle.
- Buffers fetched {pc, inst} pairs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump target) with flush, and a level-sensitive halt.

Parameters:
- ADDR_W, 12, PC and instruction-memory address width.
- INST_W, 16, instruction word width.
- RESET_PC, 12'h000, PC value loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- imem_addr  out  ADDR_W  address to instruction memory; equals the fetch_pc register.
- imem_inst  in  INST_W  word at imem_addr, valid in the same cycle.
- redirect_valid  in  1  single-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch target.
- halt  in  1  level; while high, no new fetches are issued.
- id_valid  out  1  FIFO head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_inst  out  INST_W  head instruction.
- id_pc  out  ADDR_W  PC of the head instruction.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - fetch_pc=RESET_PC; FIFO pointers=0; fifo_count=0; id_valid=0; id_inst=0; id_pc=0.
  - Overrides every other input.
- Definitions:
  - pop = id_valid & id_ready.
  - push = !halt & !redirect_valid & (fifo_count<FIFO_DEPTH | pop).
- On push:
  - Write {fetch_pc, imem_inst} at the tail.
  - fetch_pc <= fetch_pc+1, wrapping 12'hFFF -> 12'h000.
- On pop: advance the head.
- Simultaneous push and pop when full: legal, and occupancy stays at FIFO_DEPTH.
- Simultaneous push and pop when empty: not possible, because id_valid=0.
- id_valid/id_inst/id_pc are driven from FIFO storage (registered), never combinationally from imem_inst.
- Latency: a word fetched in cycle N is visible at decode in cycle N+1. First cycle after reset release: imem_addr=RESET_PC, so id_valid=1 with id_pc=RESET_PC one cycle later.
- Redirect (cycle N):
  - Flush the FIFO (count=0) and set fetch_pc <= redirect_pc.
  - No push in cycle N. Any pop in cycle N is still honoured, so decode consumed that head.
  - Cycle N+1: id_valid=0, imem_addr=redirect_pc.
  - Cycle N+2: id_valid=1, id_pc=redirect_pc (if halt is low).
  - Redirect has priority over both push and halt. A redirect while halted still updates fetch_pc and flushes.
- Halt: pushes stop immediately, pops continue, so the FIFO drains. When halt deasserts, fetch resumes from the held fetch_pc with no skipped or duplicated PCs.
- Back-pressure: with id_ready=0 the FIFO fills to FIFO_DEPTH. fetch_pc then freezes, and imem_addr stays stable until a slot frees.
- The head (id_inst, id_pc) holds stable while id_valid=1 and id_ready=0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds two outputs:
  - perf_fetched (16 bits): increments on every push.
  - perf_stall (16 bits): increments each cycle with !halt & !redirect_valid & !push, i.e. full-FIFO stall.
  - Both reset to 0 and wrap at 16'hFFFF -> 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, id_ready=1 continuously, memory holds ram[0]=16'h0008, ram[1]=16'h1001 -> cycle 1: id_pc=0, id_inst=16'h0008; cycle 2: id_pc=1, id_inst=16'h1001; one instruction per cycle thereafter.
- id_ready=0 from reset -> fifo_count reaches 2 at cycle 2 and imem_addr holds 12'h002. Raise id_ready -> id_pc sequence 0,1,2,3 with no gaps or duplicates.
- Steady stream at id_pc=5, assert redirect_valid with redirect_pc=12'h008 for one cycle -> next cycle id_valid=0, fifo_count=0; following cycle id_pc=8, id_inst=16'hE000.
- Start fetch_pc at 12'hFFE via redirect -> id_pc sequence FFE, FFF, 000, 001.
- halt=1 for 4 cycles with id_ready=1 -> FIFO drains to 0 and id_valid=0; after halt drops, the next id_pc is the successor of the last delivered PC.
- With FETCH_PERF_CNT_EN defined: 10 cycles of id_ready=0 after reset -> perf_fetched=2, perf_stall=8.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for fetch_unit.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface fetch_unit_if #(
  parameter int ADDR_W     = 12,
  parameter int INST_W     = 16,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output id_valid,
    input  id_ready,
    output id_inst,
    output id_pc,
    output fifo_count
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  id_valid,
    output id_ready,
    input  id_inst,
    input  id_pc,
    input  fifo_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, prefetch FIFO of {pc, inst}, redirect/flush and halt.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter int                ADDR_W     = 12,
  parameter int                INST_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = 12'h000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stall,
`endif
  fetch_unit_if.master bus
);

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_pc_mem   [FIFO_DEPTH];
  logic [INST_W-1:0] r_inst_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_valid;
  logic w_pop;
  logic w_push;

  // Handshake qualifiers; a push into a full FIFO is allowed only alongside a pop
  assign w_valid = (r_count != {CNT_W{1'b0}});
  assign w_pop   = w_valid & bus.id_ready;
  assign w_push  = ~bus.halt & ~bus.redirect_valid & ((r_count < DEPTH_C) | w_pop);

  // Decode sees only FIFO storage, never the memory word directly
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.id_valid   = w_valid;
  assign bus.id_inst    = r_inst_mem[r_rd_ptr];
  assign bus.id_pc      = r_pc_mem[r_rd_ptr];
  assign bus.fifo_count = r_count;

  // PC, pointers and occupancy; redirect flushes and wins over push and halt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= bus.redirect_pc;
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads zero until the first fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pc_mem[i]   <= {ADDR_W{1'b0}};
        r_inst_mem[i] <= {INST_W{1'b0}};
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_inst_mem[r_wr_ptr] <= bus.imem_inst;
    end else begin
      r_pc_mem[r_wr_ptr]   <= r_pc_mem[r_wr_ptr];
      r_inst_mem[r_wr_ptr] <= r_inst_mem[r_wr_ptr];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_stall;

  // Stall counts cycles that wanted to fetch but found the FIFO full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetched <= 16'h0000;
      r_perf_stall   <= 16'h0000;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 16'h0001;
      end
      if (~bus.halt & ~bus.redirect_valid & ~w_push) begin
        r_perf_stall <= r_perf_stall + 16'h0001;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(12), .INST_W(16), .FIFO_DEPTH(2)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  fetch_unit #(.ADDR_W(12), .INST_W(16), .RESET_PC(12'h000), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
`endif
    .bus          (bus)
  );

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    case (a)
      12'h000: mem_word = 16'h0008;
      12'h001: mem_word = 16'h1001;
      12'h008: mem_word = 16'hE000;
      default: mem_word = {4'hA, a};
    endcase
  endfunction

  assign bus.imem_inst = mem_word(bus.imem_addr);

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        halt;
    logic        redir;
    logic [11:0] rpc;
    logic        chk_head;
    logic        valid;
    logic [11:0] pc;
    logic [15:0] inst;
    logic [1:0]  count;
    logic [11:0] addr;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic r, input logic rdy, input logic h, input logic rv,
                              input logic [11:0] rpc, input logic ch, input logic v,
                              input logic [11:0] pc, input logic [15:0] inst,
                              input logic [1:0] cnt, input logic [11:0] addr);
    vec_t t;
    t.rst_n = r;  t.ready = rdy; t.halt = h; t.redir = rv; t.rpc = rpc;
    t.chk_head = ch; t.valid = v; t.pc = pc; t.inst = inst; t.count = cnt; t.addr = addr;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic h, input logic rv, input logic [11:0] rpc);
    @(negedge clk);
    rst_n              = r;
    bus.id_ready       = rdy;
    bus.halt           = h;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.id_ready       = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 12'h000;

    //           rst rdy hlt rdr rpc      chk vld pc       inst      cnt   addr
    vecs.push_back(mk(0, 1, 0, 0, 12'h000, 1, 0, 12'h000, 16'h0000, 2'd0, 12'h000));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h000, 16'h0008, 2'd1, 12'h001));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h001, 16'h1001, 2'd1, 12'h002));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h002, 16'hA002, 2'd1, 12'h003));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h003, 16'hA003, 2'd1, 12'h004));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h004, 16'hA004, 2'd1, 12'h005));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h005, 16'hA005, 2'd1, 12'h006));
    // redirect to 008 from a steady stream
    vecs.push_back(mk(1, 1, 0, 1, 12'h008, 0, 0, 12'h000, 16'h0000, 2'd0, 12'h008));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h008, 16'hE000, 2'd1, 12'h009));
    // PC wrap FFE -> 001
    vecs.push_back(mk(1, 1, 0, 1, 12'hFFE, 0, 0, 12'h000, 16'h0000, 2'd0, 12'hFFE));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'hFFE, 16'hAFFE, 2'd1, 12'hFFF));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'hFFF, 16'hAFFF, 2'd1, 12'h000));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h000, 16'h0008, 2'd1, 12'h001));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h001, 16'h1001, 2'd1, 12'h002));
    // halt for 4 cycles drains, then resumes at 002
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, 1, 0, 12'h000, 0, 0, 12'h000, 16'h0000, 2'd0, 12'h002));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h002, 16'hA002, 2'd1, 12'h003));
    // back-pressure from reset
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 1, 0, 12'h000, 16'h0000, 2'd0, 12'h000));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 1, 1, 12'h000, 16'h0008, 2'd1, 12'h001));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 1, 1, 12'h000, 16'h0008, 2'd2, 12'h002));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 1, 1, 12'h000, 16'h0008, 2'd2, 12'h002));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h001, 16'h1001, 2'd2, 12'h003));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h002, 16'hA002, 2'd2, 12'h004));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h003, 16'hA003, 2'd2, 12'h005));
    // redirect while halted still flushes and moves the PC
    vecs.push_back(mk(1, 0, 1, 1, 12'h010, 0, 0, 12'h000, 16'h0000, 2'd0, 12'h010));
    vecs.push_back(mk(1, 0, 1, 0, 12'h000, 0, 0, 12'h000, 16'h0000, 2'd0, 12'h010));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 1, 1, 12'h010, 16'hA010, 2'd1, 12'h011));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].ready, vecs[i].halt, vecs[i].redir, vecs[i].rpc);
      chk("id_valid", i, {15'h0000, bus.id_valid}, {15'h0000, vecs[i].valid});
      chk("fifo_count", i, {14'h0000, bus.fifo_count}, {14'h0000, vecs[i].count});
      chk("imem_addr", i, {4'h0, bus.imem_addr}, {4'h0, vecs[i].addr});
      if (vecs[i].chk_head) begin
        chk("id_pc", i, {4'h0, bus.id_pc}, {4'h0, vecs[i].pc});
        chk("id_inst", i, bus.id_inst, vecs[i].inst);
      end
    end

    // Head and address stay frozen while full and decode stalls
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
      chk("stall_count", 100 + i, {14'h0000, bus.fifo_count}, 16'h0002);
      chk("stall_pc", 100 + i, {4'h0, bus.id_pc}, 16'h0010);
      chk("stall_inst", 100 + i, bus.id_inst, 16'hA010);
      chk("stall_addr", 100 + i, {4'h0, bus.imem_addr}, 16'h0012);
    end

`ifdef FETCH_PERF_CNT_EN
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    chk("perf_fetched_rst", 200, perf_fetched, 16'h0000);
    chk("perf_stall_rst", 200, perf_stall, 16'h0000);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    chk("perf_fetched", 201, perf_fetched, 16'h0002);
    chk("perf_stall", 201, perf_stall, 16'h0008);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
